// File: rtl/noc_tx_arbiter.sv
// noc_tx_arbiter
// Packet-level round-robin arbiter sharing the single noc_to_dev byte channel
// among NREQ requesters. A requester is granted for a whole packet (header
// through last byte); its bytes are registered onto noc_to_dev_ctl/data with
// one cycle of latency. The idle byte is ctl=1, data=8'h00.
//
// Build option: define NOC_ARB_GAP_EN to add a GAP state after every packet.
// That state gives the switch at least three idle bytes between packets.
// Without the macro, a packet is followed by a single IDLE cycle.
module noc_tx_arbiter #(
  parameter int NREQ = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NREQ-1:0]   req_valid,
  input  logic [NREQ*8-1:0] req_data,
  input  logic [NREQ-1:0]   req_last,
  output logic [NREQ-1:0]   req_ready,
  output logic              noc_to_dev_ctl,
  output logic [7:0]        noc_to_dev_data,
  output logic [2:0]        grant_id,
  output logic              busy
);

  localparam int IW = $clog2(NREQ);

`ifdef NOC_ARB_GAP_EN
  typedef enum logic [1:0] {ST_IDLE, ST_XFER, ST_GAP} state_t;
`else
  typedef enum logic {ST_IDLE, ST_XFER} state_t;
`endif

  state_t          state;
  logic [IW-1:0]   ptr;        // highest-priority requester for the next arbitration
  logic [IW-1:0]   gidx;       // current (or most recent) owner of the channel
  logic            first;      // next accepted byte is the packet header
`ifdef NOC_ARB_GAP_EN
  logic [1:0]      gap_cnt;
`endif

  logic [NREQ-1:0] rot_valid;
  logic [IW-1:0]   pick_off;
  logic [IW:0]     pick_sum;
  logic [IW-1:0]   pick_idx;
  logic            pick_any;
  logic [IW-1:0]   next_ptr;
  logic            g_valid;
  logic            g_last;
  logic [7:0]      g_data;

  // Round-robin pick: rotate so ptr sits at bit 0, take the lowest set bit,
  // then rotate the offset back into a requester index.
  always_comb begin
    // NOTE: every variable assigned in a combinational block gets a default
    // first, so no path leaves it holding a stale value (an inferred latch).
    rot_valid = NREQ'({req_valid, req_valid} >> ptr);
    pick_any  = |req_valid;
    pick_off  = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (rot_valid[i]) pick_off = IW'(i);
    end
    pick_sum = {1'b0, ptr} + {1'b0, pick_off};
    if (pick_sum >= (IW+1)'(NREQ)) pick_sum = pick_sum - (IW+1)'(NREQ);
    pick_idx = pick_sum[IW-1:0];
  end

  // The granted requester's handshake lane and the pointer that follows it.
  assign g_valid  = req_valid[gidx];
  assign g_last   = req_last[gidx];
  assign g_data   = req_data[{gidx, 3'b000} +: 8];
  assign next_ptr = (gidx == IW'(NREQ - 1)) ? '0 : gidx + IW'(1);
  assign grant_id = 3'(gidx);

  // Only the owner sees ready, and only while a packet is in flight.
  always_comb begin
    req_ready = '0;
    if (state == ST_XFER) req_ready[gidx] = 1'b1;
  end

  // Packet FSM with registered channel outputs; the idle byte is the default
  // every cycle and is overridden only by an accepted byte.
  always_ff @(posedge clk) begin
    // NOTE: state and output registers use non-blocking assignments so every
    // right-hand side reads the value from before this clock edge.
    if (reset) begin
      state           <= ST_IDLE;
      ptr             <= '0;
      gidx            <= '0;
      first           <= 1'b0;
      busy            <= 1'b0;
      noc_to_dev_ctl  <= 1'b1;
      noc_to_dev_data <= 8'h00;
`ifdef NOC_ARB_GAP_EN
      gap_cnt         <= '0;
`endif
    end else begin
      noc_to_dev_ctl  <= 1'b1;
      noc_to_dev_data <= 8'h00;
      case (state)
        ST_IDLE: begin
          if (pick_any) begin
            gidx  <= pick_idx;
            first <= 1'b1;
            busy  <= 1'b1;
            state <= ST_XFER;
          end
        end
        ST_XFER: begin
          // A stall (owner not valid) leaves first untouched, so a header
          // stalled before acceptance is still sent with ctl=1.
          if (g_valid) begin
            noc_to_dev_ctl  <= first;
            noc_to_dev_data <= g_data;
            first           <= 1'b0;
            if (g_last) begin
              ptr <= next_ptr;
`ifdef NOC_ARB_GAP_EN
              gap_cnt <= 2'd1;
              state   <= ST_GAP;
`else
              busy    <= 1'b0;
              state   <= ST_IDLE;
`endif
            end
          end
        end
`ifdef NOC_ARB_GAP_EN
        ST_GAP: begin
          // Two GAP cycles plus the IDLE cycle yield three idle bytes.
          if (gap_cnt == 2'd0) begin
            busy  <= 1'b0;
            state <= ST_IDLE;
          end else begin
            gap_cnt <= gap_cnt - 2'd1;
          end
        end
`endif
        default: begin
          busy  <= 1'b0;
          state <= ST_IDLE;
        end
      endcase
    end
  end

  // Structural invariants of the arbiter.
  assert property (@(posedge clk) $onehot0(req_ready));
  assert property (@(posedge clk) disable iff (reset) busy == (state != ST_IDLE));
  assert property (@(posedge clk) disable iff (reset) int'(gidx) < NREQ);

endmodule

// File: tb/tb_noc_tx_arbiter.sv
// tb_noc_tx_arbiter
// Self-checking bench for noc_tx_arbiter (NREQ=4). It uses a vector table,
// hand-written multi-cycle sequences, and a randomized run scored against a
// packet-level reference model. Build with NOC_ARB_GAP_EN for the gap variant.
module tb_noc_tx_arbiter;

  localparam int NREQ = 4;
`ifdef NOC_ARB_GAP_EN
  localparam bit GAP_ON   = 1'b1;
  localparam int GAP_HOLD = 2;
  localparam int IDLE_GAP = 3;
`else
  localparam bit GAP_ON   = 1'b0;
  localparam int GAP_HOLD = 0;
  localparam int IDLE_GAP = 1;
`endif

  logic              clk;
  logic              reset;
  logic [NREQ-1:0]   req_valid;
  logic [NREQ*8-1:0] req_data;
  logic [NREQ-1:0]   req_last;
  logic [NREQ-1:0]   req_ready;
  logic              noc_to_dev_ctl;
  logic [7:0]        noc_to_dev_data;
  logic [2:0]        grant_id;
  logic              busy;

  int n_cmp = 0;
  int n_bad = 0;

  noc_tx_arbiter #(.NREQ(NREQ)) dut (
    .clk             (clk),
    .reset           (reset),
    .req_valid       (req_valid),
    .req_data        (req_data),
    .req_last        (req_last),
    .req_ready       (req_ready),
    .noc_to_dev_ctl  (noc_to_dev_ctl),
    .noc_to_dev_data (noc_to_dev_data),
    .grant_id        (grant_id),
    .busy            (busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    reset     = 1'b1;
    req_valid = '0;
    req_last  = '0;
    req_data  = '0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic [3:0] valid;
    logic [3:0] last;
    logic [7:0] din;
    logic [3:0] ready;
    logic       ctl;
    logic [7:0] data;
    logic [2:0] grant;
    logic       busy;
  } vec_t;

  vec_t tbl [14];

  // ---------------- stream helper ----------------
  int hdr_q[$];
  int gap_q[$];

  // Requesters in mask send 2-byte packets continuously: header 8'h10+i and
  // last byte 8'hE0+i. The task records header order and idle runs between packets.
  task automatic run_stream(input logic [3:0] mask, input int npk);
    int         bi [NREQ];
    logic [3:0] acc;
    int         idle_run;
    bit         seen_last;
    hdr_q.delete();
    gap_q.delete();
    for (int i = 0; i < NREQ; i++) bi[i] = 0;
    idle_run  = 0;
    seen_last = 1'b0;
    for (int cyc = 0; cyc < 200 && hdr_q.size() < npk; cyc++) begin
      for (int i = 0; i < NREQ; i++) begin
        req_valid[i]     = mask[i];
        req_data[8*i +: 8] = (bi[i] == 0) ? 8'(8'h10 + i) : 8'(8'hE0 + i);
        req_last[i]      = (bi[i] == 1);
      end
      acc = req_ready & req_valid;
      @(posedge clk);
      #1;
      for (int i = 0; i < NREQ; i++) if (acc[i]) bi[i] = 1 - bi[i];
      if (noc_to_dev_ctl && noc_to_dev_data != 8'h00) begin
        if (seen_last) gap_q.push_back(idle_run);
        hdr_q.push_back(int'(noc_to_dev_data) - 16);
        idle_run = 0;
      end else if (noc_to_dev_ctl) begin
        idle_run++;
      end else begin
        seen_last = 1'b1;
        idle_run  = 0;
      end
    end
    req_valid = '0;
    req_last  = '0;
  endtask

  // ---------------- reference model ----------------
  // Packet-level view: who owns the channel, whose turn is next, and how many
  // recovery cycles remain before the next arbitration.
  int         m_owner;
  int         m_base;
  int         m_grant;
  int         m_hold;
  bit         m_first;
  logic       m_ctl;
  logic [7:0] m_data;

  task automatic model_reset();
    m_owner = -1;
    m_base  = 0;
    m_grant = 0;
    m_hold  = 0;
    m_first = 1'b0;
    m_ctl   = 1'b1;
    m_data  = 8'h00;
  endtask

  task automatic model_step(input logic [3:0] v, input logic [3:0] l, input logic [31:0] d);
    int c;
    m_ctl  = 1'b1;
    m_data = 8'h00;
    if (m_owner >= 0) begin
      if (v[m_owner]) begin
        m_ctl   = m_first;
        m_data  = d[8*m_owner +: 8];
        m_first = 1'b0;
        if (l[m_owner]) begin
          m_base  = (m_owner + 1) % NREQ;
          m_owner = -1;
          m_hold  = GAP_HOLD;
        end
      end
    end else if (m_hold > 0) begin
      m_hold--;
    end else begin
      for (int k = 0; k < NREQ; k++) begin
        c = (m_base + k) % NREQ;
        if (v[c]) begin
          m_owner = c;
          m_grant = c;
          m_first = 1'b1;
          break;
        end
      end
    end
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int         fo[5];
    int         po[4];
    logic [3:0] vld;
    logic [3:0] lst;
    logic [3:0] acc;
    logic [3:0] m_rdy;
    bit         act [NREQ];
    int         plen [NREQ];
    int         ppos [NREQ];
    logic [7:0] cur [NREQ];
    bit         rst_now;

    // Reset held 3 cycles with every requester valid.
    reset     = 1'b1;
    req_valid = 4'b1111;
    req_last  = 4'b1111;
    req_data  = {4{8'h3C}};
    repeat (3) @(posedge clk);
    #1;
    check("rst_ready", req_ready, 4'b0000);
    check("rst_ctl", noc_to_dev_ctl, 1'b1);
    check("rst_data", noc_to_dev_data, 8'h00);
    check("rst_grant", grant_id, 3'd0);
    check("rst_busy", busy, 1'b0);
    reset = 1'b0;

    // Single requester, stall inside a packet, non-granted valid ignored.
    tbl[0]  = '{4'b0010, 4'b0000, 8'hA5, 4'b0010, 1'b1, 8'h00, 3'd1, 1'b1};
    tbl[1]  = '{4'b0010, 4'b0000, 8'hA5, 4'b0010, 1'b1, 8'hA5, 3'd1, 1'b1};
    tbl[2]  = '{4'b0010, 4'b0000, 8'h11, 4'b0010, 1'b0, 8'h11, 3'd1, 1'b1};
    tbl[3]  = '{4'b0010, 4'b0010, 8'h22, 4'b0000, 1'b0, 8'h22, 3'd1, GAP_ON};
    tbl[4]  = '{4'b0000, 4'b0000, 8'h00, 4'b0000, 1'b1, 8'h00, 3'd1, GAP_ON};
    tbl[5]  = '{4'b0000, 4'b0000, 8'h00, 4'b0000, 1'b1, 8'h00, 3'd1, 1'b0};
    tbl[6]  = '{4'b0100, 4'b0000, 8'hC3, 4'b0100, 1'b1, 8'h00, 3'd2, 1'b1};
    tbl[7]  = '{4'b0100, 4'b0000, 8'hC3, 4'b0100, 1'b1, 8'hC3, 3'd2, 1'b1};
    tbl[8]  = '{4'b0001, 4'b0001, 8'h66, 4'b0100, 1'b1, 8'h00, 3'd2, 1'b1};
    tbl[9]  = '{4'b0001, 4'b0001, 8'h66, 4'b0100, 1'b1, 8'h00, 3'd2, 1'b1};
    tbl[10] = '{4'b0100, 4'b0000, 8'h44, 4'b0100, 1'b0, 8'h44, 3'd2, 1'b1};
    tbl[11] = '{4'b0100, 4'b0100, 8'h55, 4'b0000, 1'b0, 8'h55, 3'd2, GAP_ON};
    tbl[12] = '{4'b0000, 4'b0000, 8'h00, 4'b0000, 1'b1, 8'h00, 3'd2, GAP_ON};
    tbl[13] = '{4'b0000, 4'b0000, 8'h00, 4'b0000, 1'b1, 8'h00, 3'd2, 1'b0};
    for (int r = 0; r < 14; r++) begin
      req_valid = tbl[r].valid;
      req_last  = tbl[r].last;
      req_data  = {4{tbl[r].din}};
      @(posedge clk);
      #1;
      check($sformatf("tbl%0d_ready", r), req_ready, tbl[r].ready);
      check($sformatf("tbl%0d_ctl", r), noc_to_dev_ctl, tbl[r].ctl);
      check($sformatf("tbl%0d_data", r), noc_to_dev_data, tbl[r].data);
      check($sformatf("tbl%0d_grant", r), grant_id, tbl[r].grant);
      check($sformatf("tbl%0d_busy", r), busy, tbl[r].busy);
    end

    // Fairness: all four requesters busy, 2-byte packets.
    do_reset();
    run_stream(4'b1111, 5);
    fo = '{0, 1, 2, 3, 0};
    check("fair_headers", hdr_q.size(), 5);
    for (int k = 0; k < hdr_q.size() && k < 5; k++)
      check($sformatf("fair_grant%0d", k), hdr_q[k], fo[k]);
    check("fair_gaps", gap_q.size(), 4);
    for (int k = 0; k < gap_q.size(); k++)
      check($sformatf("fair_idle%0d", k), gap_q[k], IDLE_GAP);

    // Back-to-back packets from requesters 0 and 3.
    do_reset();
    run_stream(4'b1001, 4);
    po = '{0, 3, 0, 3};
    check("pair_headers", hdr_q.size(), 4);
    for (int k = 0; k < hdr_q.size() && k < 4; k++)
      check($sformatf("pair_grant%0d", k), hdr_q[k], po[k]);
    for (int k = 0; k < gap_q.size(); k++)
      check($sformatf("pair_idle%0d", k), gap_q[k], IDLE_GAP);

    // Reset during the second payload byte of requester 2 (pointer was 2).
    do_reset();
    req_valid = 4'b0010;
    req_last  = 4'b0010;
    req_data  = {4{8'h77}};
    repeat (2) @(posedge clk);
    #1;
    req_valid = '0;
    req_last  = '0;
    repeat (4) @(posedge clk);
    #1;
    req_valid = 4'b0100;
    req_data  = {4{8'h99}};
    @(posedge clk);
    #1;
    check("rmid_grant2", grant_id, 3'd2);
    @(posedge clk);
    #1;
    check("rmid_header", {noc_to_dev_ctl, noc_to_dev_data}, 9'h199);
    req_data = {4{8'h01}};
    @(posedge clk);
    #1;
    req_data = {4{8'h02}};
    reset    = 1'b1;
    @(posedge clk);
    #1;
    check("rmid_ctl", noc_to_dev_ctl, 1'b1);
    check("rmid_data", noc_to_dev_data, 8'h00);
    check("rmid_busy", busy, 1'b0);
    check("rmid_ready", req_ready, 4'b0000);
    check("rmid_grant", grant_id, 3'd0);
    reset     = 1'b0;
    req_valid = 4'b1111;
    req_data  = {4{8'h5A}};
    @(posedge clk);
    #1;
    check("rmid_regrant", grant_id, 3'd0);
    check("rmid_regrant_ready", req_ready, 4'b0001);
    @(posedge clk);
    #1;
    check("rmid_rehdr", {noc_to_dev_ctl, noc_to_dev_data}, 9'h15A);

    // Randomized traffic against the reference model.
    do_reset();
    model_reset();
    for (int i = 0; i < NREQ; i++) begin
      act[i]  = 1'b0;
      plen[i] = 1;
      ppos[i] = 0;
      cur[i]  = 8'h01;
    end
    for (int cyc = 0; cyc < 4000; cyc++) begin
      rst_now = ($urandom_range(0, 599) == 0);
      for (int i = 0; i < NREQ; i++) begin
        if (!act[i] && $urandom_range(0, 3) == 0) begin
          act[i]  = 1'b1;
          plen[i] = $urandom_range(1, 4);
          ppos[i] = 0;
          cur[i]  = 8'($urandom_range(1, 255));
        end
        vld[i] = act[i] && ($urandom_range(0, 3) != 0);
        lst[i] = act[i] && (ppos[i] == plen[i] - 1);
        req_data[8*i +: 8] = cur[i];
      end
      req_valid = vld;
      req_last  = lst;
      reset     = rst_now;
      acc = '0;
      if (!rst_now && m_owner >= 0 && vld[m_owner]) acc[m_owner] = 1'b1;
      if (rst_now) model_reset();
      else model_step(vld, lst, req_data);
      m_rdy = (m_owner >= 0) ? 4'(1 << m_owner) : 4'b0000;
      @(posedge clk);
      #1;
      check($sformatf("rand_cyc%0d {ready,ctl,data,grant,busy}", cyc),
            {15'd0, req_ready, noc_to_dev_ctl, noc_to_dev_data, grant_id, busy},
            {15'd0, m_rdy, m_ctl, m_data, 3'(m_grant), (m_owner >= 0) || (m_hold > 0)});
      for (int i = 0; i < NREQ; i++) begin
        if (rst_now) begin
          act[i] = 1'b0;
        end else if (acc[i]) begin
          if (ppos[i] == plen[i] - 1) begin
            act[i] = 1'b0;
          end else begin
            ppos[i]++;
            cur[i] = 8'($urandom_range(0, 255));
          end
        end
      end
    end
    reset     = 1'b0;
    req_valid = '0;
    req_last  = '0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
